// File: rtl/wb_write_buffer.sv
// Writeback stage with a 2-entry write buffer that shares the register-file port with decode reads; writes issue >=1 cycle after accept, oReady drops when both entries are held.
// Define WB_BYPASS_EN to add combinational forwarding of pending (uncommitted) writes to decode.
module wb_write_buffer #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic                  iRegWrite,
  input  logic                  iMemToReg,
  input  logic [REG_ADDR_W-1:0] iDestReg,
  input  logic [DATA_W-1:0]     iAluResult,
  input  logic [DATA_W-1:0]     iMemData,
  input  logic [1:0]            iLoadSize,
  input  logic                  iLoadUnsigned,
  input  logic [1:0]            iByteOff,
  input  logic                  iRdReq,
  output logic                  oRegWr,
  output logic [REG_ADDR_W-1:0] oWrReg3,
  output logic [DATA_W-1:0]     oWrData,
  output logic                  oRdStall,
  output logic [CNT_W-1:0]      oRetireCnt
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] iRdAddr1,
  input  logic [REG_ADDR_W-1:0] iRdAddr2,
  output logic                  oFwd1Hit,
  output logic                  oFwd2Hit,
  output logic [DATA_W-1:0]     oFwd1Data,
  output logic [DATA_W-1:0]     oFwd2Data
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     dat;
  } ent_t;

  ent_t            ent0, ent1, new_ent;
  logic [1:0]      count;
  logic [SW-1:0]   starve;
  logic            accept, push, pop, force_wr;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [DATA_W-1:0] ld_ext;

  assign oReady   = (count < 2'd2);
  assign accept   = iValid & oReady;
  assign push     = accept & iRegWrite & (iDestReg != '0);
  assign force_wr = (starve == SW'(STARVE_MAX));
  assign oRegWr   = (count != 2'd0) & (~iRdReq | force_wr);
  assign pop      = oRegWr;
  assign oWrReg3  = oRegWr ? ent0.rd  : '0;
  assign oWrData  = oRegWr ? ent0.dat : '0;
  assign oRdStall = oRegWr & iRdReq;

  // Little-endian lane select, then extension; size 2'b11 falls through to word.
  always_comb begin
    ld_byte = iMemData[{iByteOff, 3'b000} +: 8];
    ld_half = iByteOff[1] ? iMemData[31:16] : iMemData[15:0];
    case (iLoadSize)
      2'b01:   ld_ext = iLoadUnsigned ? {{(DATA_W-16){1'b0}}, ld_half}
                                      : {{(DATA_W-16){ld_half[15]}}, ld_half};
      2'b10:   ld_ext = iLoadUnsigned ? {{(DATA_W-8){1'b0}}, ld_byte}
                                      : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      default: ld_ext = iMemData;
    endcase
    new_ent.rd  = iDestReg;
    new_ent.dat = iMemToReg ? ld_ext : iAluResult;
  end

  // ent0 is always the head; a pop shifts ent1 down.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      count      <= 2'd0;
      starve     <= '0;
      oRetireCnt <= '0;
      ent0       <= '0;
      ent1       <= '0;
    end else begin
      if (accept)
        oRetireCnt <= oRetireCnt + 1'b1;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= new_ent;
          else               ent1 <= new_ent;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: ent0 <= new_ent;
        default: ;
      endcase
      if (pop || count == 2'd0)
        starve <= '0;
      else if (iRdReq && !force_wr)
        starve <= starve + 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Youngest pending entry wins when both match.
  always_comb begin
    oFwd1Hit  = 1'b0;
    oFwd1Data = '0;
    oFwd2Hit  = 1'b0;
    oFwd2Data = '0;
    if (iRdAddr1 != '0) begin
      if (count == 2'd2 && ent1.rd == iRdAddr1) begin
        oFwd1Hit  = 1'b1;
        oFwd1Data = ent1.dat;
      end else if (count != 2'd0 && ent0.rd == iRdAddr1) begin
        oFwd1Hit  = 1'b1;
        oFwd1Data = ent0.dat;
      end
    end
    if (iRdAddr2 != '0) begin
      if (count == 2'd2 && ent1.rd == iRdAddr2) begin
        oFwd2Hit  = 1'b1;
        oFwd2Data = ent1.dat;
      end else if (count != 2'd0 && ent0.rd == iRdAddr2) begin
        oFwd2Hit  = 1'b1;
        oFwd2Data = ent0.dat;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed self-checking bench for wb_write_buffer; bypass scenario runs only when WB_BYPASS_EN is defined.
module tb_wb_write_buffer;

  logic        clk = 1'b0;
  logic        reset, valid, ready, reg_write, mem_to_reg, load_unsigned, rd_req;
  logic [4:0]  dest_reg, wr_reg;
  logic [31:0] alu_result, mem_data, wr_data, retire_cnt;
  logic [1:0]  load_size, byte_off;
  logic        reg_wr, rd_stall;
`ifdef WB_BYPASS_EN
  logic [4:0]  rd_addr1, rd_addr2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_retire = 0;

  always #5 clk = ~clk;

  wb_write_buffer dut (
    .iClk(clk), .iReset(reset), .iValid(valid), .oReady(ready),
    .iRegWrite(reg_write), .iMemToReg(mem_to_reg), .iDestReg(dest_reg),
    .iAluResult(alu_result), .iMemData(mem_data), .iLoadSize(load_size),
    .iLoadUnsigned(load_unsigned), .iByteOff(byte_off), .iRdReq(rd_req),
    .oRegWr(reg_wr), .oWrReg3(wr_reg), .oWrData(wr_data), .oRdStall(rd_stall),
    .oRetireCnt(retire_cnt)
`ifdef WB_BYPASS_EN
    , .iRdAddr1(rd_addr1), .iRdAddr2(rd_addr2), .oFwd1Hit(fwd1_hit),
    .oFwd2Hit(fwd2_hit), .oFwd1Data(fwd1_data), .oFwd2Data(fwd2_data)
`endif
  );

  task automatic idle();
    valid = 0; reg_write = 0; mem_to_reg = 0; dest_reg = 0; alu_result = 0;
    mem_data = 0; load_size = 0; load_unsigned = 0; byte_off = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer_alu(input logic [4:0] rd, input logic [31:0] val);
    valid = 1; reg_write = 1; mem_to_reg = 0; dest_reg = rd; alu_result = val;
  endtask

  task automatic test_reset();
    idle(); rd_req = 0; reset = 1;
`ifdef WB_BYPASS_EN
    rd_addr1 = 0; rd_addr2 = 0;
`endif
    next_cycle(); next_cycle();
    reset = 0; #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL reset_regwr: got %b want 0", reg_wr); end
    checks++; if (wr_reg !== 5'd0) begin errors++; $display("FAIL reset_wrreg: got %0d want 0", wr_reg); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wrdata: got %h want 0", wr_data); end
    checks++; if (rd_stall !== 1'b0) begin errors++; $display("FAIL reset_rdstall: got %b want 0", rd_stall); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire: got %0d want 0", retire_cnt); end
    exp_retire = 0;
  endtask

  task automatic test_alu_write();
    offer_alu(5'd5, 32'h1234); #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL alu_early_wr: got %b want 0", reg_wr); end
    next_cycle(); exp_retire++;
    idle(); #1;
    checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL alu_wr: got %b want 1", reg_wr); end
    checks++; if (wr_reg !== 5'd5) begin errors++; $display("FAIL alu_reg: got %0d want 5", wr_reg); end
    checks++; if (wr_data !== 32'h1234) begin errors++; $display("FAIL alu_data: got %h want 00001234", wr_data); end
    checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL alu_retire: got %0d want %0d", retire_cnt, exp_retire); end
    next_cycle(); #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL alu_drained: got %b want 0", reg_wr); end
  endtask

  task automatic test_load_ext();
    logic [1:0]  sz [7]  = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10};
    logic        un [7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  off [7] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1};
    logic [31:0] exp [7] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                             32'h80FF7F01, 32'h80FF7F01, 32'h0000007F};
    for (int i = 0; i < 7; i++) begin
      valid = 1; reg_write = 1; mem_to_reg = 1; dest_reg = 5'd9;
      alu_result = 32'hDEADBEEF; mem_data = 32'h80FF7F01;
      load_size = sz[i]; load_unsigned = un[i]; byte_off = off[i];
      next_cycle(); exp_retire++;
      idle(); #1;
      checks++; if (reg_wr !== 1'b1 || wr_data !== exp[i])
        begin errors++; $display("FAIL load_%0d: got wr=%b data=%h want wr=1 data=%h", i, reg_wr, wr_data, exp[i]); end
      next_cycle();
    end
  endtask

  task automatic test_no_write();
    offer_alu(5'd0, 32'h5555);
    next_cycle(); exp_retire++;
    offer_alu(5'd3, 32'h6666); reg_write = 0; #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL r0_wr: got %b want 0", reg_wr); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b want 1", ready); end
    checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL r0_retire: got %0d want %0d", retire_cnt, exp_retire); end
    next_cycle(); exp_retire++;
    idle(); #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL nowrite_wr: got %b want 0", reg_wr); end
    checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL nowrite_retire: got %0d want %0d", retire_cnt, exp_retire); end
  endtask

  task automatic test_starvation();
    rd_req = 1;
    offer_alu(5'd1, 32'h11); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL starve_ready0: got %b want 1", ready); end
    next_cycle(); exp_retire++;
    offer_alu(5'd2, 32'h22); #1;
    checks++; if (ready !== 1'b1 || reg_wr !== 1'b0) begin errors++; $display("FAIL starve_b: ready=%b wr=%b want 1 0", ready, reg_wr); end
    next_cycle(); exp_retire++;
    offer_alu(5'd3, 32'h33);
    // Cycles with starve = 1..3 (plus the second-accept cycle above) must not write.
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ready !== 1'b0 || reg_wr !== 1'b0)
        begin errors++; $display("FAIL starve_hold_%0d: ready=%b wr=%b want 0 0", i, ready, reg_wr); end
      next_cycle();
    end
    #1;
    checks++; if (reg_wr !== 1'b1 || rd_stall !== 1'b1) begin errors++; $display("FAIL starve_force: wr=%b stall=%b want 1 1", reg_wr, rd_stall); end
    checks++; if (wr_reg !== 5'd1 || wr_data !== 32'h11) begin errors++; $display("FAIL starve_head: reg=%0d data=%h want 1 00000011", wr_reg, wr_data); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL starve_full: got %b want 0", ready); end
    next_cycle(); #1;
    checks++; if (ready !== 1'b1 || reg_wr !== 1'b0) begin errors++; $display("FAIL starve_after: ready=%b wr=%b want 1 0", ready, reg_wr); end
    next_cycle(); exp_retire++;
    idle(); rd_req = 0; #1;
    checks++; if (reg_wr !== 1'b1 || rd_stall !== 1'b0 || wr_reg !== 5'd2 || wr_data !== 32'h22)
      begin errors++; $display("FAIL starve_drain2: wr=%b stall=%b reg=%0d data=%h want 1 0 2 00000022", reg_wr, rd_stall, wr_reg, wr_data); end
    next_cycle(); #1;
    checks++; if (reg_wr !== 1'b1 || wr_reg !== 5'd3 || wr_data !== 32'h33)
      begin errors++; $display("FAIL starve_drain3: wr=%b reg=%0d data=%h want 1 3 00000033", reg_wr, wr_reg, wr_data); end
    checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL starve_retire: got %0d want %0d", retire_cnt, exp_retire); end
    next_cycle(); #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL starve_empty: got %b want 0", reg_wr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'h44, 32'h55, 32'h66};
    rd_req = 0;
    offer_alu(5'd4, vals[0]);
    next_cycle(); exp_retire++;
    for (int i = 1; i < 3; i++) begin
      offer_alu(5'd4, vals[i]); #1;
      checks++; if (ready !== 1'b1 || reg_wr !== 1'b1 || wr_data !== vals[i-1])
        begin errors++; $display("FAIL b2b_%0d: ready=%b wr=%b data=%h want 1 1 %h", i, ready, reg_wr, wr_data, vals[i-1]); end
      next_cycle(); exp_retire++;
    end
    idle(); #1;
    checks++; if (reg_wr !== 1'b1 || wr_reg !== 5'd4 || wr_data !== vals[2])
      begin errors++; $display("FAIL b2b_last: wr=%b reg=%0d data=%h want 1 4 %h", reg_wr, wr_reg, wr_data, vals[2]); end
    next_cycle(); #1;
    checks++; if (reg_wr !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL b2b_empty: wr=%b ready=%b want 0 1", reg_wr, ready); end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    rd_req = 1;
    offer_alu(5'd7, 32'hA); next_cycle(); exp_retire++;
    offer_alu(5'd7, 32'hB); next_cycle(); exp_retire++;
    idle(); rd_addr1 = 5'd7; rd_addr2 = 5'd0; #1;
    checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hB) begin errors++; $display("FAIL fwd1: hit=%b data=%h want 1 0000000b", fwd1_hit, fwd1_data); end
    checks++; if (fwd2_hit !== 1'b0) begin errors++; $display("FAIL fwd2_r0: got %b want 0", fwd2_hit); end
    rd_addr2 = 5'd8; #1;
    checks++; if (fwd2_hit !== 1'b0) begin errors++; $display("FAIL fwd2_miss: got %b want 0", fwd2_hit); end
    rd_req = 0; rd_addr1 = 0; rd_addr2 = 0;
    next_cycle(); next_cycle(); #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL fwd_drain: got %b want 0", reg_wr); end
  endtask
`endif

  task automatic test_reset_mid();
    rd_req = 1;
    offer_alu(5'd6, 32'h77); next_cycle();
    offer_alu(5'd6, 32'h88); next_cycle();
    idle(); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_full: got %b want 0", ready); end
    reset = 1; next_cycle(); reset = 0; rd_req = 0; exp_retire = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (reg_wr !== 1'b0 || ready !== 1'b1)
        begin errors++; $display("FAIL rstmid_%0d: wr=%b ready=%b want 0 1", i, reg_wr, ready); end
      next_cycle();
    end
    checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL rstmid_retire: got %0d want 0", retire_cnt); end
  endtask

  initial begin
    idle(); rd_req = 0; reset = 1;
    @(negedge clk);
    test_reset();
    test_alu_write();
    test_load_ext();
    test_no_write();
    test_starvation();
    test_back_to_back();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
